// File: rtl/two_to_four_decoder_sequencer.sv
// Buffered 2:4 decoder: accepts 2-bit codes through a 2-entry FIFO and plays each one
// out as a one-hot pulse HOLD_CYCLES long, followed by GAP_CYCLES low and one idle cycle.
module two_to_four_decoder_sequencer #(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in0,
  input  logic in1,
  input  logic in_valid,
  output logic in_ready,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] y;

  logic [1:0] fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic       push;
  logic       pop;
  logic [1:0] head_code;
  logic [3:0] head_onehot;

  // Readiness comes only from the registered count, so a full FIFO never takes a code
  // even on the cycle it is being popped.
  assign in_ready  = (count < 2'd2);
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && (count != 2'd0);
  assign busy      = (state != IDLE) || (count != 2'd0);
  assign head_code = fifo_mem[rd_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign head_onehot[gi] = (head_code == 2'(gi));
    end
  endgenerate

  assign y0 = y[0];
  assign y1 = y[1];
  assign y2 = y[2];
  assign y3 = y[3];

  // Storage carries no reset; validity is tracked entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in1, in0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      y     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            y     <= head_onehot;
            cnt   <= 4'd0;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == HOLD_LAST) begin
            y     <= 4'd0;
            cnt   <= 4'd0;
            state <= GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          y     <= 4'd0;
          cnt   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
